// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared types, codes and helpers for the 4x4 Connect4 move sequencer
package connect4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [3:0] COL0   = 4'b1110;
  localparam logic [3:0] COL1   = 4'b1101;
  localparam logic [3:0] COL2   = 4'b1011;
  localparam logic [3:0] COL3   = 4'b0111;
  localparam logic [3:0] NO_COL = 4'b1111;

  localparam logic [2:0] COL_FULL = 3'd4;
  localparam logic [4:0] POS_NONE = 5'b11111;

  typedef struct packed {
    logic       hit;
    logic [1:0] col;
  } col_sel_t;

  // Only the four single-zero codes count as a column; everything else is noise.
  function automatic col_sel_t decode_col(input logic [3:0] sel);
    col_sel_t r;
    r.hit = 1'b1;
    r.col = 2'd0;
    case (sel)
      COL0:    r.col = 2'd0;
      COL1:    r.col = 2'd1;
      COL2:    r.col = 2'd2;
      COL3:    r.col = 2'd3;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] player_code(input logic player);
    return player ? P2 : P1;
  endfunction

endpackage

// File: rtl/connect4_win_checker.sv
// rtl/connect4_win_checker.sv - combinational four-in-a-line detector for one player
module connect4_win_checker (
  input  logic [31:0] board_i,
  input  logic [1:0]  player_i,
  output logic        win_o
);

  logic [15:0] own;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      own[i] = (board_i[2*i +: 2] == player_i);
    end
    win_o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      win_o |= &own[4*k +: 4];
      win_o |= own[k] & own[k+4] & own[k+8] & own[k+12];
    end
    win_o |= own[0] & own[5] & own[10] & own[15];
    win_o |= own[3] & own[6] & own[9]  & own[12];
  end

endmodule

// File: rtl/connect4_move_sequencer.sv
// rtl/connect4_move_sequencer.sv - one-move-per-press turn controller owning board, fill counters and game result
module connect4_move_sequencer
  import connect4_pkg::*;
#(
  parameter logic START_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic [3:0]  selected_column,
  output logic [11:0] counters,
  output logic [31:0] board,
  output logic [4:0]  column_position,
  output logic        current_player,
  output logic        move_valid,
  output logic        move_reject,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw
);

  state_e           state_q, state_d;
  logic [3:0]       sel_q;
  logic [3:0][2:0]  cnt_q, cnt_d;
  logic [31:0]      board_q, board_d;
  logic [1:0]       col_q, col_d;
  logic [4:0]       pos_q, pos_d;
  logic             player_q, player_d;
  logic             valid_q, valid_d;
  logic             reject_q, reject_d;
  logic             over_q, over_d;
  logic [1:0]       winner_q, winner_d;
  logic             draw_q, draw_d;

  col_sel_t         dec;
  logic             press, full, all_full, win;
  logic [1:0]       cur_code;
  logic [3:0]       drop_idx;

  assign dec      = decode_col(selected_column);
  assign press    = dec.hit && (sel_q == NO_COL);
  assign full     = (cnt_q[dec.col] == COL_FULL);
  assign all_full = (cnt_q[0] == COL_FULL) && (cnt_q[1] == COL_FULL) &&
                    (cnt_q[2] == COL_FULL) && (cnt_q[3] == COL_FULL);
  assign cur_code = player_code(player_q);
  assign drop_idx = {cnt_q[col_q][1:0], col_q};

  connect4_win_checker u_win (
    .board_i  (board_q),
    .player_i (cur_code),
    .win_o    (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= NO_COL;
      cnt_q    <= '0;
      board_q  <= {16{EMPTY}};
      col_q    <= 2'd0;
      pos_q    <= POS_NONE;
      player_q <= START_PLAYER;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= EMPTY;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= selected_column;
      cnt_q    <= cnt_d;
      board_q  <= board_d;
      col_q    <= col_d;
      pos_q    <= pos_d;
      player_q <= player_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (press && !full) state_d = PLACE;
        PLACE:   state_d = CHECK;
        CHECK:   state_d = (win || all_full) ? OVER : IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  // new_game overrides any in-flight move, so a press in PLACE/CHECK is simply lost.
  always_comb begin
    cnt_d    = cnt_q;
    board_d  = board_q;
    col_d    = col_q;
    pos_d    = pos_q;
    player_d = player_q;
    valid_d  = 1'b0;
    reject_d = 1'b0;
    over_d   = over_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    if (new_game) begin
      cnt_d    = '0;
      board_d  = {16{EMPTY}};
      col_d    = 2'd0;
      pos_d    = POS_NONE;
      player_d = START_PLAYER;
      over_d   = 1'b0;
      winner_d = EMPTY;
      draw_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            if (full) reject_d = 1'b1;
            else      col_d    = dec.col;
          end
        end
        PLACE: begin
          board_d[{drop_idx, 1'b0} +: 2] = cur_code;
          cnt_d[col_q] = cnt_q[col_q] + 3'd1;
          pos_d        = {cnt_q[col_q], col_q};
          valid_d      = 1'b1;
        end
        CHECK: begin
          if (win) begin
            winner_d = cur_code;
            over_d   = 1'b1;
          end else if (all_full) begin
            draw_d = 1'b1;
            over_d = 1'b1;
          end else begin
            player_d = ~player_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign counters        = cnt_q;
  assign board           = board_q;
  assign column_position = pos_q;
  assign current_player  = player_q;
  assign move_valid      = valid_q;
  assign move_reject     = reject_q;
  assign game_over       = over_q;
  assign winner          = winner_q;
  assign draw            = draw_q;

endmodule

// File: tb/tb_connect4_move_sequencer.sv
// tb/tb_connect4_move_sequencer.sv - randomized and directed bench against a grid-level game model
module tb_connect4_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_game;
  logic [3:0]  selected_column;
  logic [11:0] counters;
  logic [31:0] board;
  logic [4:0]  column_position;
  logic        current_player, move_valid, move_reject, game_over, draw;
  logic [1:0]  winner;

  int tests_run = 0;
  int tests_failed = 0;
  int seen_valid = 0, seen_reject = 0, seen_both = 0;

  int m_cell [16];
  int m_h [4];
  int m_player, m_winner, m_pos, m_valid, m_reject;
  bit m_over, m_draw;

  int line_start [10] = '{0, 4, 8, 12, 0, 1, 2, 3, 0, 3};
  int line_step  [10] = '{1, 1, 1, 1, 4, 4, 4, 4, 5, 3};
  int draw_seq   [16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};

  always #5 clk = ~clk;

  connect4_move_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .new_game        (new_game),
    .selected_column (selected_column),
    .counters        (counters),
    .board           (board),
    .column_position (column_position),
    .current_player  (current_player),
    .move_valid      (move_valid),
    .move_reject     (move_reject),
    .game_over       (game_over),
    .winner          (winner),
    .draw            (draw)
  );

  always @(negedge clk) begin
    if (move_valid === 1'b1) seen_valid++;
    if (move_reject === 1'b1) seen_reject++;
    if (move_valid === 1'b1 && move_reject === 1'b1) seen_both++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] col_code(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return ~v;
  endfunction

  function automatic bit m_wins(input int p);
    bit all;
    for (int k = 0; k < 10; k++) begin
      all = 1'b1;
      for (int j = 0; j < 4; j++)
        if (m_cell[line_start[k] + j*line_step[k]] != p) all = 1'b0;
      if (all) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_cell[i] = 0;
    for (int c = 0; c < 4; c++) m_h[c] = 0;
    m_player = 0;
    m_winner = 0;
    m_pos    = 31;
    m_over   = 1'b0;
    m_draw   = 1'b0;
  endtask

  task automatic m_press(input int c);
    if (m_over) return;
    if (m_h[c] == 4) begin
      m_reject++;
      return;
    end
    m_pos = m_h[c]*4 + c;
    m_cell[m_pos] = m_player + 1;
    m_h[c]++;
    m_valid++;
    if (m_wins(m_player + 1)) begin
      m_winner = m_player + 1;
      m_over   = 1'b1;
    end else if (m_h[0] + m_h[1] + m_h[2] + m_h[3] == 16) begin
      m_draw = 1'b1;
      m_over = 1'b1;
    end else begin
      m_player ^= 1;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] exp_board;
    logic [11:0] exp_cnt;
    for (int i = 0; i < 16; i++) exp_board[2*i +: 2] = 2'(m_cell[i]);
    for (int c = 0; c < 4; c++) exp_cnt[3*c +: 3] = 3'(m_h[c]);
    check_eq({tag, "/board"}, board, exp_board);
    check_eq({tag, "/counters"}, {20'd0, counters}, {20'd0, exp_cnt});
    check_eq({tag, "/position"}, {27'd0, column_position}, 32'(m_pos));
    check_eq({tag, "/player"}, {31'd0, current_player}, 32'(m_player));
    check_eq({tag, "/game_over"}, {31'd0, game_over}, {31'd0, m_over});
    check_eq({tag, "/winner"}, {30'd0, winner}, 32'(m_winner));
    check_eq({tag, "/draw"}, {31'd0, draw}, {31'd0, m_draw});
    check_eq({tag, "/valid_pulses"}, seen_valid, m_valid);
    check_eq({tag, "/reject_pulses"}, seen_reject, m_reject);
  endtask

  task automatic do_press(input int c, input int hold);
    selected_column = col_code(c);
    tick(hold);
    selected_column = 4'b1111;
    tick(4);
    m_press(c);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    tick(1);
    m_reset();
  endtask

  task automatic do_noise();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if (v == 4'b1111 || v == 4'b1110 || v == 4'b1101 || v == 4'b1011 || v == 4'b0111)
      v = 4'b1100;
    selected_column = v;
    tick(2);
    selected_column = 4'b1111;
    tick(2);
  endtask

  initial begin
    int moves;
    rst_n = 1'b0;
    new_game = 1'b0;
    selected_column = 4'b1111;
    m_reset();
    m_valid = 0;
    m_reject = 0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    compare_model("reset");

    // first drop: exact pulse latency
    selected_column = 4'b1110;
    tick(1);
    check_eq("lat/valid_early", {31'd0, move_valid}, 32'd0);
    check_eq("lat/board_early", board, 32'd0);
    selected_column = 4'b1111;
    tick(1);
    check_eq("lat/valid_on", {31'd0, move_valid}, 32'd1);
    check_eq("lat/cell0", {30'd0, board[1:0]}, 32'd1);
    check_eq("lat/pos", {27'd0, column_position}, 32'd0);
    check_eq("lat/cnt0", {29'd0, counters[2:0]}, 32'd1);
    tick(1);
    check_eq("lat/valid_off", {31'd0, move_valid}, 32'd0);
    check_eq("lat/player", {31'd0, current_player}, 32'd1);
    tick(2);
    m_press(0);
    compare_model("first");

    do_press(1, 10);
    compare_model("hold");
    check_eq("hold/cnt1", {29'd0, counters[5:3]}, 32'd1);
    check_eq("hold/pos", {27'd0, column_position}, 32'd1);

    selected_column = 4'b1100;
    tick(3);
    selected_column = 4'b0000;
    tick(3);
    selected_column = 4'b1111;
    tick(3);
    compare_model("illegal");

    // P1 stacks column 0 while P2 answers in column 1
    do_new_game();
    for (int k = 0; k < 7; k++) do_press(k % 2, 1);
    compare_model("colwin");
    check_eq("colwin/winner", {30'd0, winner}, 32'd1);
    check_eq("colwin/over", {31'd0, game_over}, 32'd1);
    do_press(2, 1);
    do_press(0, 2);
    compare_model("over_ignored");

    // button held across new_game must not fire
    selected_column = 4'b1110;
    tick(3);
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    tick(4);
    selected_column = 4'b1111;
    tick(3);
    m_reset();
    compare_model("held_newgame");

    for (int k = 0; k < 5; k++) do_press(2, 1);
    compare_model("full_col");
    check_eq("full_col/cnt2", {29'd0, counters[8:6]}, 32'd4);
    check_eq("full_col/player", {31'd0, current_player}, 32'd0);

    do_new_game();
    foreach (draw_seq[k]) do_press(draw_seq[k], 1);
    compare_model("draw");
    check_eq("draw/flag", {31'd0, draw}, 32'd1);
    check_eq("draw/winner", {30'd0, winner}, 32'd0);
    do_new_game();
    compare_model("after_draw");
    check_eq("after_draw/pos", {27'd0, column_position}, 32'd31);

    for (int g = 0; g < 5; g++) begin
      do_new_game();
      moves = 0;
      while (!m_over && moves < 40) begin
        if ($urandom_range(0, 7) == 0) do_noise();
        if (g == 1 && moves == 3) begin
          // new_game lands while the move sits in PLACE
          selected_column = col_code(int'($urandom_range(0, 3)));
          tick(1);
          new_game = 1'b1;
          selected_column = 4'b1111;
          tick(1);
          new_game = 1'b0;
          tick(3);
          m_reset();
          compare_model("abort_place");
        end
        do_press(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
        moves++;
        compare_model($sformatf("rand%0d_%0d", g, moves));
      end
      do_press(int'($urandom_range(0, 3)), 1);
      compare_model($sformatf("rand%0d_end", g));
    end

    check_eq("exclusive_pulses", seen_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
